gate_guard: RTL and testbench
=============================

# gate_guard

Gate-signal protection stage placed directly downstream of the DAB switch-pattern generator and directly upstream of the gate-driver pins. It registers the eight raw switching commands (`Sp_in`, `Ss_in`), checks every half-bridge leg for shoot-through and insufficient dead time, and forwards the commands only while armed and fault-free. On any violation or external fault it forces all gates off within one cycle, latches the cause, and re-arms only after an explicit clear and a hold-off period.

## Interface
- `MIN_DT`, default 2: minimum both-off cycles required in a leg before either switch of that leg may turn on. Must be at least 1.
- `FAULT_HOLD`, default 16: number of cycles spent in HOLD after a clear, before returning to IDLE. Must be at least 1.
- `clk` input, 1 bit: system clock. Single clock domain.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `en` input, 1 bit: run request.
- `Sp_in` input, 4 bits: primary commands {Sp1,Sp2,Sp3,Sp4}. Leg PA is bits [3:2]; leg PB is bits [1:0].
- `Ss_in` input, 4 bits: secondary commands {Ss1,Ss2,Ss3,Ss4}. Leg SA is bits [3:2]; leg SB is bits [1:0].
- `fault_ext` input, 1 bit: external desaturation/overcurrent flag, active-high. Already synchronous to `clk`.
- `clear` input, 1 bit: fault clear request, level-sensitive.
- `Sp` output, 4 bits: guarded primary gate signals.
- `Ss` output, 4 bits: guarded secondary gate signals.
- `fault` output, 1 bit: latched fault indicator. High in FAULT and HOLD.
- `fault_code` output, 3 bits: latched cause. Bit 0 = external, bit 1 = shoot-through, bit 2 = dead-time violation.
- `fault_leg` output, 4 bits: latched offending legs {PA,PB,SA,SB}.

## Operation
- **Stage 1 (s1):** every edge registers `Sp_in`, `Ss_in`, `en`, `fault_ext` and `clear`. All checks and state decisions use s1 values only.
- **Per-leg dead-time counter:**
  - Reset value is `MIN_DT` (saturated).
  - Clears to 0 on any cycle where either s1 switch of the leg is high.
  - Otherwise increments, saturating at `MIN_DT`.
  - Counters run in every state.
- **Shoot-through:** both s1 switches of a leg are high.
- **Dead-time violation:** a switch of the leg rises (s1 high, previous s1 low) while that leg's counter is below `MIN_DT`. This also catches an off-then-on glitch on the same switch.
- **States:** IDLE, RUN, FAULT, HOLD. Encoding is free.
  - **IDLE:** outputs 0. Go to RUN when s1 `en`=1 and all eight s1 commands are 0. This prevents arming mid-pulse.
  - **RUN:** outputs follow s1 commands.
    - Any violation or s1 `fault_ext` → FAULT.
    - Otherwise s1 `en`=0 → IDLE.
  - **FAULT:** outputs 0, `fault`=1. Go to HOLD when s1 `clear`=1 and s1 `fault_ext`=0.
  - **HOLD:** outputs 0, `fault`=1, hold counter runs from 0.
    - s1 `fault_ext`=1 → back to FAULT. Cause and legs are re-latched, and the counter restarts on the next clear.
    - Counter reaches `FAULT_HOLD`-1 → IDLE, clearing `fault`, `fault_code` and `fault_leg`.
- **External fault from any state:** s1 `fault_ext`=1 in IDLE, RUN or HOLD sends the FSM to FAULT.
- **Violations outside RUN:** ignored in IDLE and HOLD, because outputs are already 0.
- **Cause latching:** on entry to FAULT, `fault_code` and `fault_leg` take the OR of all causes and legs present in that cycle. While in FAULT they do not change.
- **Reset:**
  - `Sp`=0, `Ss`=0, `fault`=0, `fault_code`=0, `fault_leg`=0.
  - State IDLE; all s1 registers 0; dead-time counters `MIN_DT`; hold counter 0.

## Timing
- **Pass-through latency:** 2 edges. An input applied before edge k appears on `Sp`/`Ss` after edge k+1.
- **Violating inputs never reach the outputs.** If a violation or `fault_ext` is captured into s1 at edge k, the output register loads 0 at edge k+1, and the state is FAULT after edge k+1.
- **`en` deassertion:** outputs are 0 from edge k+1, where edge k captured `en`=0.
- **Clear to re-arm:** `clear` captured at edge k → HOLD after k+1 → IDLE after k+1+`FAULT_HOLD` → RUN possible one edge later.
- **Asynchronous reset mid-pulse:** outputs drop to 0 immediately, without waiting for a clock edge.

## Test plan
- **Normal pass-through** (`MIN_DT`=2): `en`=1, all commands 0 for 3 cycles; then PA = 10, 00, 00, 01. Required: `Sp[3:2]` reproduces 10, 00, 00, 01 delayed 2 cycles; `fault`=0.
- **Shoot-through:** in RUN, drive `Sp_in`=4'b1100 for one cycle. Required: `Sp`/`Ss` never show 1100 and are 0 on the next edge; `fault`=1, `fault_code`=3'b010, `fault_leg`=4'b1000.
- **Dead-time violation:** in RUN, SB = 10, 00, 01 (one off cycle). Required: FAULT; `fault_code`=3'b100; `fault_leg`=4'b0001; `Ss[0]` never goes high.
- **External fault plus recovery:** pulse `fault_ext` for 1 cycle in RUN; then assert `clear` for 1 cycle. Required:
  - outputs 0 and `fault_code`=3'b001 after the fault;
  - `fault` stays 1 for exactly 16 cycles of HOLD;
  - IDLE, then RUN resumes once commands are all 0.
- **Fault during HOLD:** assert `fault_ext` on the 5th HOLD cycle. Required: back to FAULT with `fault` still 1, and a new `clear` is needed.
- **Async reset mid-pulse:** `Sp`=1000 in RUN, drop `rst` between edges. Required: `Sp`=0 immediately; all outputs at reset values; IDLE after `rst` is released.

Source files
------------

// File: rtl/gate_guard.sv
// Gate-signal protection stage: registers raw DAB switch commands, checks each
// half-bridge leg for shoot-through and dead-time violations, and blanks gates on fault.
module gate_guard #(
  parameter int MIN_DT     = 2,
  parameter int FAULT_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] Sp_in,
  input  logic [3:0] Ss_in,
  input  logic       fault_ext,
  input  logic       clear,
  output logic [3:0] Sp,
  output logic [3:0] Ss,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_leg
);

  localparam int DW = $clog2(MIN_DT + 1);
  localparam int HW = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
  localparam logic [DW-1:0] DT_SAT    = DW'(MIN_DT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FAULT_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT, S_HOLD} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    cmd_s1_reg, cmd_prev_reg;
  logic          en_s1_reg, fext_s1_reg, clr_s1_reg;
  logic [3:0]    st_leg, dt_leg;
  logic          run_viol;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0]    out_reg, out_next;
  logic [2:0]    code_reg, code_next;
  logic [3:0]    leg_reg, leg_next;

  // Command word is {Sp,Ss}; leg gi occupies bits [2*gi+1:2*gi], so leg 3 = PA, leg 0 = SB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_s1_reg   <= '0;
      cmd_prev_reg <= '0;
      en_s1_reg    <= 1'b0;
      fext_s1_reg  <= 1'b0;
      clr_s1_reg   <= 1'b0;
    end else begin
      cmd_s1_reg   <= {Sp_in, Ss_in};
      cmd_prev_reg <= cmd_s1_reg;
      en_s1_reg    <= en;
      fext_s1_reg  <= fault_ext;
      clr_s1_reg   <= clear;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_leg
      logic [DW-1:0] dt_cnt_reg;
      logic [1:0]    leg_cmd, leg_rise;

      assign leg_cmd    = cmd_s1_reg[2*gi+1:2*gi];
      assign leg_rise   = leg_cmd & ~cmd_prev_reg[2*gi+1:2*gi];
      assign st_leg[gi] = &leg_cmd;
      assign dt_leg[gi] = (|leg_rise) && (dt_cnt_reg < DT_SAT);

      // Counts consecutive both-off cycles; saturation means the leg may switch on.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dt_cnt_reg <= DT_SAT;
        end else if (|leg_cmd) begin
          dt_cnt_reg <= '0;
        end else if (dt_cnt_reg < DT_SAT) begin
          dt_cnt_reg <= dt_cnt_reg + DW'(1);
        end
      end
    end
  endgenerate

  assign run_viol = |(st_leg | dt_leg);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    out_next      = '0;
    code_next     = code_reg;
    leg_next      = leg_reg;
    case (state_reg)
      S_IDLE: begin
        if (fext_s1_reg) begin
          state_next = S_FAULT;
          code_next  = 3'b001;
          leg_next   = '0;
        end else if (en_s1_reg && (cmd_s1_reg == '0)) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (fext_s1_reg || run_viol) begin
          state_next = S_FAULT;
          code_next  = {|dt_leg, |st_leg, fext_s1_reg};
          leg_next   = st_leg | dt_leg;
        end else if (!en_s1_reg) begin
          state_next = S_IDLE;
        end else begin
          out_next = cmd_s1_reg;
        end
      end
      S_FAULT: begin
        if (clr_s1_reg && !fext_s1_reg) begin
          state_next    = S_HOLD;
          hold_cnt_next = '0;
        end
      end
      S_HOLD: begin
        if (fext_s1_reg) begin
          state_next = S_FAULT;
          code_next  = 3'b001;
          leg_next   = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = S_IDLE;
          code_next  = '0;
          leg_next   = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
      out_reg      <= '0;
      code_reg     <= '0;
      leg_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      out_reg      <= out_next;
      code_reg     <= code_next;
      leg_reg      <= leg_next;
    end
  end

  assign Sp         = out_reg[7:4];
  assign Ss         = out_reg[3:0];
  assign fault      = (state_reg == S_FAULT) || (state_reg == S_HOLD);
  assign fault_code = code_reg;
  assign fault_leg  = leg_reg;

endmodule

// File: tb/tb_gate_guard.sv
// Self-checking bench for gate_guard: vector table fed through a two-edge scoreboard,
// plus hand-written reset sequences.
module tb_gate_guard;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] Sp_in, Ss_in;
  logic       fault_ext, clear;
  logic [3:0] Sp, Ss;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_leg;

  int checks = 0;
  int errors = 0;

  gate_guard #(.MIN_DT(2), .FAULT_HOLD(16)) dut (
    .clk(clk), .rst(rst), .en(en), .Sp_in(Sp_in), .Ss_in(Ss_in),
    .fault_ext(fault_ext), .clear(clear), .Sp(Sp), .Ss(Ss),
    .fault(fault), .fault_code(fault_code), .fault_leg(fault_leg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic       en;
    logic [3:0] sp, ss;
    logic       fx, clr;
    logic [3:0] esp, ess;
    logic       ef;
    logic [2:0] ecode;
    logic [3:0] eleg;
  } vec_t;

  typedef struct {
    logic       chk;
    int         idx;
    logic [3:0] sp, ss;
    logic       f;
    logic [2:0] code;
    logic [3:0] leg;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input logic e, input logic [3:0] sp, input logic [3:0] ss,
                     input logic fx, input logic clr, input logic [3:0] esp,
                     input logic [3:0] ess, input logic ef, input logic [2:0] ec,
                     input logic [3:0] el);
    vec_t v;
    v.en = e; v.sp = sp; v.ss = ss; v.fx = fx; v.clr = clr;
    v.esp = esp; v.ess = ess; v.ef = ef; v.ecode = ec; v.eleg = el;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic [3:0] esp, input logic [3:0] ess,
                           input logic ef, input logic [2:0] ec, input logic [3:0] el);
    checks++;
    if (Sp !== esp || Ss !== ess || fault !== ef || fault_code !== ec || fault_leg !== el) begin
      errors++;
      $display("FAIL %s: got Sp=%b Ss=%b fault=%b code=%b leg=%b, expected Sp=%b Ss=%b fault=%b code=%b leg=%b",
               name, Sp, Ss, fault, fault_code, fault_leg, esp, ess, ef, ec, el);
    end else begin
      $display("ok   %s: Sp=%b Ss=%b fault=%b code=%b leg=%b", name, Sp, Ss, fault, fault_code, fault_leg);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] sp, input logic [3:0] ss,
                       input logic fx, input logic clr);
    en = e; Sp_in = sp; Ss_in = ss; fault_ext = fx; clear = clr;
  endtask

  // Compare the entry pushed two steps ago: its outputs appear after the second edge.
  task automatic sb_step(input logic chk, input int idx, input vec_t v);
    exp_t x;
    if (exp_q.size() == 2) begin
      x = exp_q.pop_front();
      if (x.chk) check_out($sformatf("vec%0d", x.idx), x.sp, x.ss, x.f, x.code, x.leg);
    end
    drive(v.en, v.sp, v.ss, v.fx, v.clr);
    x.chk = chk; x.idx = idx; x.sp = v.esp; x.ss = v.ess;
    x.f = v.ef; x.code = v.ecode; x.leg = v.eleg;
    exp_q.push_back(x);
  endtask

  initial begin
    vec_t last;
    rst = 1'b0;
    drive(0, 4'b0, 4'b0, 0, 0);

    // Pass-through and arming
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b1001, 0, 0, 4'b0000, 4'b1001, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0001, 4'b0110, 0, 0, 4'b0001, 4'b0110, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    // Shoot-through on PA, then clear and a full 16-cycle hold
    add(1, 4'b1100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b010, 4'b1000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b010, 4'b1000);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 1, 3'b010, 4'b1000);
    for (int j = 0; j < 15; j++)
      add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b010, 4'b1000);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    // Dead-time violation on SB (only one off cycle)
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0010, 0, 0, 4'b0000, 4'b0010, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 3'b100, 4'b0001);
    // Clear, then external fault inside HOLD re-latches the cause
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 1, 3'b100, 4'b0001);
    for (int j = 0; j < 3; j++)
      add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b100, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    for (int j = 0; j < 5; j++)
      add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    for (int j = 0; j < 15; j++)
      add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    // External fault in RUN; clear ignored while fault_ext is still high
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    for (int j = 0; j < 15; j++)
      add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 3'b001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    // en deassertion and no arming mid-pulse
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0000, 0, 3'b000, 4'b0000);
    add(0, 4'b1000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b1000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    // Violations in IDLE are ignored
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(0, 4'b1100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 4'b0000);
    add(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 3'b000, 4'b0000);

    repeat (2) @(negedge clk);
    check_out("reset_state", 4'b0, 4'b0, 1'b0, 3'b0, 4'b0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      sb_step(1'b1, i, vecs[i]);
    end
    last = vecs[vecs.size()-1];
    repeat (2) begin
      @(negedge clk);
      sb_step(1'b0, -1, last);
    end
    exp_q.delete();

    // Async reset in the middle of a pulse
    drive(1, 4'b0000, 4'b0000, 0, 0);
    repeat (3) @(negedge clk);
    drive(1, 4'b1000, 4'b0000, 0, 0);
    repeat (2) @(negedge clk);
    check_out("pulse_before_reset", 4'b1000, 4'b0000, 1'b0, 3'b0, 4'b0);
    rst = 1'b0;
    #1;
    check_out("async_reset_drop", 4'b0, 4'b0, 1'b0, 3'b0, 4'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_out($sformatf("idle_after_reset%0d", j), 4'b0, 4'b0, 1'b0, 3'b0, 4'b0);
    end
    drive(1, 4'b0000, 4'b0000, 0, 0);
    repeat (3) @(negedge clk);
    drive(1, 4'b1000, 4'b0000, 0, 0);
    repeat (2) @(negedge clk);
    check_out("rearm_after_reset", 4'b1000, 4'b0000, 1'b0, 3'b0, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
